// File: rtl/fda_pkg.sv
// Shared definitions for the capture packetizer.
//   SYNC0/SYNC1 : packet header bytes
//   state_t     : packetizer FSM state encoding
package fda_pkg;

    localparam logic [7:0] SYNC0 = 8'hA5;
    localparam logic [7:0] SYNC1 = 8'h5A;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_SYNC0   = 4'd1,
        S_SYNC1   = 4'd2,
        S_REQ     = 4'd3,
        S_WAITV   = 4'd4,
        S_SEND_HI = 4'd5,
        S_SEND_LO = 4'd6,
        S_CNT_HI  = 4'd7,
        S_CNT_LO  = 4'd8,
        S_CSUM    = 4'd9
    } state_t;

endpackage

// File: rtl/capture_packetizer_if.sv
// Bus between the packetizer, the capture buffer and the byte transmitter.
//   Capture side : dataReadyToRead, dataEmpty, dataValid, dataIn (to packetizer);
//                  dataRead, readyToTransmit, abortFlag (from packetizer)
//   Transmit side: txBusy (to packetizer); txByte, txStrobe (from packetizer)
// master = packetizer, slave = capture buffer / transmitter environment.
interface capture_packetizer_if;

    logic        dataReadyToRead;
    logic        dataEmpty;
    logic        dataValid;
    logic [15:0] dataIn;
    logic        dataRead;
    logic        readyToTransmit;
    logic        abortFlag;
    logic        txBusy;
    logic [7:0]  txByte;
    logic        txStrobe;

    modport master (
        input  dataReadyToRead, dataEmpty, dataValid, dataIn, txBusy,
        output dataRead, readyToTransmit, abortFlag, txByte, txStrobe
    );

    modport slave (
        output dataReadyToRead, dataEmpty, dataValid, dataIn, txBusy,
        input  dataRead, readyToTransmit, abortFlag, txByte, txStrobe
    );

endinterface

// File: rtl/capture_packetizer_byte_tx_handshake.sv
// Byte-load handshake towards a UART/FTDI style transmitter.
//   clk, rst  : clock, synchronous active-high reset
//   load      : a byte is waiting to be sent
//   byteIn    : the byte to send
//   txBusy    : transmitter busy (rises the cycle after txStrobe)
//   txByte    : registered byte, stable while txStrobe is high
//   txStrobe  : one-cycle load pulse
//   accepted  : high on the strobe cycle; the caller advances on it
module byte_tx_handshake (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] byteIn,
    input  logic       txBusy,
    output logic [7:0] txByte,
    output logic       txStrobe,
    output logic       accepted
);

    // Gating on the previous strobe keeps the pulse one cycle wide and
    // covers the cycle before txBusy has had a chance to rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            txStrobe <= 1'b0;
            txByte   <= 8'h00;
        end else if (load && !txBusy && !txStrobe) begin
            txStrobe <= 1'b1;
            txByte   <= byteIn;
        end else begin
            txStrobe <= 1'b0;
        end
    end

    assign accepted = txStrobe;

endmodule

// File: rtl/capture_packetizer.sv
// Drains 16-bit words from the capture buffer into a byte transmitter as
// packets: A5 5A, word bytes (MSB first), count (2 B, MSB first), checksum.
//   clk, rst : clock, synchronous active-high reset
//   bus      : capture_packetizer_if.master (capture and transmit handshakes)
// Parameters:
//   MAX_WORDS     : packet closes once this many words are sent
//   VALID_TIMEOUT : cycles allowed in WAITV before the packet is aborted
module capture_packetizer
    import fda_pkg::*;
#(
    parameter int MAX_WORDS     = 1024,
    parameter int VALID_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    capture_packetizer_if.master  bus
);

    localparam int TW = $clog2(VALID_TIMEOUT) + 1;
    localparam logic [TW-1:0] T_LAST  = TW'(VALID_TIMEOUT - 1);
    localparam logic [15:0]   MAX_CNT = 16'(MAX_WORDS);

    state_t      state, stateNext;
    logic [15:0] wordCount;
    logic [15:0] word;
    logic [7:0]  checksum;
    logic [TW-1:0] timer;
    logic        readyReg;
    logic        abortReg;

    logic        load;
    logic [7:0]  sendByte;
    logic        accepted;
    logic        readReq;

    byte_tx_handshake u_tx (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .byteIn   (sendByte),
        .txBusy   (bus.txBusy),
        .txByte   (bus.txByte),
        .txStrobe (bus.txStrobe),
        .accepted (accepted)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        load      = 1'b0;
        sendByte  = 8'h00;
        readReq   = 1'b0;
        unique case (state)
            S_IDLE:
                if (bus.dataReadyToRead && !bus.dataEmpty) stateNext = S_SYNC0;
            S_SYNC0: begin
                load = 1'b1; sendByte = SYNC0;
                if (accepted) stateNext = S_SYNC1;
            end
            S_SYNC1: begin
                load = 1'b1; sendByte = SYNC1;
                if (accepted) stateNext = S_REQ;
            end
            S_REQ:
                if (bus.dataEmpty || wordCount == MAX_CNT) begin
                    stateNext = S_CNT_HI;
                end else begin
                    readReq   = 1'b1;
                    stateNext = S_WAITV;
                end
            S_WAITV:
                if (bus.dataValid)        stateNext = S_SEND_HI;
                else if (timer == T_LAST) stateNext = S_CNT_HI;
            S_SEND_HI: begin
                load = 1'b1; sendByte = word[15:8];
                if (accepted) stateNext = S_SEND_LO;
            end
            S_SEND_LO: begin
                load = 1'b1; sendByte = word[7:0];
                if (accepted) stateNext = S_REQ;
            end
            S_CNT_HI: begin
                load = 1'b1; sendByte = wordCount[15:8];
                if (accepted) stateNext = S_CNT_LO;
            end
            S_CNT_LO: begin
                load = 1'b1; sendByte = wordCount[7:0];
                if (accepted) stateNext = S_CSUM;
            end
            S_CSUM: begin
                load = 1'b1; sendByte = checksum;
                if (accepted) stateNext = S_IDLE;
            end
            default: stateNext = S_IDLE;
        endcase
    end

    // Datapath: counter, checksum, word latch, valid timer, status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wordCount <= 16'h0000;
            checksum  <= 8'h00;
            word      <= 16'h0000;
            timer     <= '0;
            readyReg  <= 1'b1;
            abortReg  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE:
                    if (stateNext == S_SYNC0) begin
                        wordCount <= 16'h0000;
                        checksum  <= 8'h00;
                        abortReg  <= 1'b0;
                        readyReg  <= 1'b0;
                    end
                S_REQ:
                    timer <= '0;
                S_WAITV:
                    if (bus.dataValid) begin
                        word     <= bus.dataIn;
                        checksum <= checksum + bus.dataIn[15:8] + bus.dataIn[7:0];
                        if (wordCount != MAX_CNT) wordCount <= wordCount + 16'd1;
                    end else if (timer == T_LAST) begin
                        abortReg <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                S_CSUM:
                    if (accepted) readyReg <= 1'b1;
                default: ;
            endcase
        end
    end

    // Combinational from REQ: the FSM leaves REQ on the same edge, so the
    // request is exactly one cycle and never overlaps an outstanding read.
    assign bus.dataRead        = readReq;
    assign bus.readyToTransmit = readyReg;
    assign bus.abortFlag       = abortReg;

endmodule
